// File: rtl/wta_disp_select.sv
// Pipelined winner-take-all disparity selector: registered arg-min tree over per-disparity
// SAD costs, tracking the second minimum so ambiguous matches can be flagged invalid.
module wta_disp_select #(
  parameter int ELEM        = 64,
  parameter int DATA_WIDTH  = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int DISP_SHIFT  = 2,
  parameter bit TIE_LOW     = 1'b1,
  parameter int INVALID_VAL = 0
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         c_en,
  input  logic                         i_valid,
  input  logic [ELEM*DATA_WIDTH-1:0]   i_sads_data,
  input  logic [3:0]                   i_uniq,
  output logic                         o_valid,
  output logic [OUT_WIDTH-1:0]         o_disp_data,
  output logic [DATA_WIDTH-1:0]        o_min_cost,
  output logic                         o_unique
);

  localparam int L   = $clog2(ELEM);
  localparam int P   = 1 << L;
  localparam int IW  = L;
  localparam int SHW = IW + DISP_SHIFT + OUT_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  typedef struct packed {
    logic                  pad;
    logic [DATA_WIDTH-1:0] minCost;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] secCost;
  } node_t;

  // Pad lanes lose every comparison, ties included, and never leak into the second minimum.
  function automatic node_t merge(input node_t a, input node_t b);
    logic                  bWins;
    node_t                 win;
    node_t                 lose;
    node_t                 res;
    logic [DATA_WIDTH-1:0] loseMin;
    if (a.pad)                         bWins = 1'b1;
    else if (b.pad)                    bWins = 1'b0;
    else if (a.minCost == b.minCost)   bWins = !TIE_LOW;
    else                               bWins = (b.minCost < a.minCost);
    win         = bWins ? b : a;
    lose        = bWins ? a : b;
    loseMin     = lose.pad ? ONES : lose.minCost;
    res.pad     = a.pad & b.pad;
    res.minCost = win.minCost;
    res.idx     = win.idx;
    res.secCost = (loseMin < win.secCost) ? loseMin : win.secCost;
    return res;
  endfunction

  for (genvar s = 0; s <= L; s++) begin : g_lvl
    localparam int NODES = P >> s;
    node_t      node [NODES];
    logic [3:0] uniq;
    logic       vld;

    if (s == 0) begin : g_leaf
      // Level 0 is the unregistered view of the input word.
      for (genvar k = 0; k < P; k++) begin : g_lane
        if (k < ELEM) begin : g_real
          assign node[k] = '{pad: 1'b0, minCost: i_sads_data[k*DATA_WIDTH +: DATA_WIDTH],
                             idx: IW'(k), secCost: ONES};
        end else begin : g_pad
          assign node[k] = '{pad: 1'b1, minCost: ONES, idx: IW'(k), secCost: ONES};
        end
      end
      assign uniq = i_uniq;
      assign vld  = i_valid;
    end else begin : g_merge
      node_t node_d [NODES];

      always_comb begin
        for (int n = 0; n < NODES; n++) begin
          node_d[n] = merge(g_lvl[s-1].node[2*n], g_lvl[s-1].node[2*n+1]);
        end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          for (int n = 0; n < NODES; n++) node[n] <= '0;
          uniq <= '0;
          vld  <= 1'b0;
        end else if (c_en) begin
          node <= node_d;
          uniq <= g_lvl[s-1].uniq;
          vld  <= g_lvl[s-1].vld;
        end
      end
    end
  end

  node_t                 root;
  logic [DATA_WIDTH+3:0] diffScaled;
  logic [DATA_WIDTH+3:0] minScaled;
  logic                  unique_d;
  logic [OUT_WIDTH-1:0]  disp_d;
  logic                  valid_q;
  logic [OUT_WIDTH-1:0]  disp_q;
  logic [DATA_WIDTH-1:0] minCost_q;
  logic                  unique_q;

  assign root = g_lvl[L].node[0];

  // Uniqueness test 16*(second-min) >= min*ratio, widened so neither side can wrap.
  always_comb begin
    diffScaled = {root.secCost - root.minCost, 4'b0000};
    minScaled  = (DATA_WIDTH+4)'(root.minCost) * (DATA_WIDTH+4)'(g_lvl[L].uniq);
    unique_d   = !root.pad && ((g_lvl[L].uniq == 4'd0) || (diffScaled >= minScaled));
    disp_d     = unique_d ? OUT_WIDTH'(SHW'(root.idx) << DISP_SHIFT) : OUT_WIDTH'(INVALID_VAL);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q   <= 1'b0;
      disp_q    <= '0;
      minCost_q <= '0;
      unique_q  <= 1'b0;
    end else if (c_en) begin
      valid_q   <= g_lvl[L].vld;
      disp_q    <= disp_d;
      minCost_q <= root.minCost;
      unique_q  <= unique_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_disp_data = disp_q;
  assign o_min_cost  = minCost_q;
  assign o_unique    = unique_q;

endmodule

// File: tb/tb_wta_disp_select.sv
// Self-checking bench for wta_disp_select: three configurations (8 lanes low/high tie-break,
// 5 lanes with pad) driven by a directed vector table, c_en/reset sequences and a random stream.
module tb_wta_disp_select;

  typedef struct {
    logic [63:0] sab;
    logic [39:0] sc;
    logic [3:0]  uq;
    int          dA;
    int          dB;
    int          mAB;
    int          uAB;
    int          dC;
    int          mC;
    int          uC;
  } vec_t;

  typedef struct {
    vec_t e;
    int   due;
  } pend_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cEn = 1'b0;
  logic        iValid = 1'b0;
  logic [63:0] sadsAB = '0;
  logic [39:0] sadsC = '0;
  logic [3:0]  iUniq = '0;

  logic       vA, vB, vC, uA, uB, uC;
  logic [7:0] dA, dB, dC, mA, mB, mC;

  int    checks = 0;
  int    errors = 0;
  int    enEdge = 0;
  vec_t  tbl [11];
  pend_t q [$];

  wta_disp_select #(.ELEM(8), .DATA_WIDTH(8), .OUT_WIDTH(8), .DISP_SHIFT(5),
                    .TIE_LOW(1'b1), .INVALID_VAL(7)) dutA (
    .aclk(aclk), .aresetn(aresetn), .c_en(cEn), .i_valid(iValid), .i_sads_data(sadsAB),
    .i_uniq(iUniq), .o_valid(vA), .o_disp_data(dA), .o_min_cost(mA), .o_unique(uA));

  wta_disp_select #(.ELEM(8), .DATA_WIDTH(8), .OUT_WIDTH(8), .DISP_SHIFT(5),
                    .TIE_LOW(1'b0), .INVALID_VAL(7)) dutB (
    .aclk(aclk), .aresetn(aresetn), .c_en(cEn), .i_valid(iValid), .i_sads_data(sadsAB),
    .i_uniq(iUniq), .o_valid(vB), .o_disp_data(dB), .o_min_cost(mB), .o_unique(uB));

  wta_disp_select #(.ELEM(5), .DATA_WIDTH(8), .OUT_WIDTH(8), .DISP_SHIFT(2),
                    .TIE_LOW(1'b0), .INVALID_VAL(0)) dutC (
    .aclk(aclk), .aresetn(aresetn), .c_en(cEn), .i_valid(iValid), .i_sads_data(sadsC),
    .i_uniq(iUniq), .o_valid(vC), .o_disp_data(dC), .o_min_cost(mC), .o_unique(uC));

  // Free-running clock shared by all three instances.
  always #5 aclk = ~aclk;

  // Watchdog so a stuck run still terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] pack8(input int c0, input int c1, input int c2, input int c3,
                                        input int c4, input int c5, input int c6, input int c7);
    return {8'(c7), 8'(c6), 8'(c5), 8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic logic [39:0] pack5(input int c0, input int c1, input int c2, input int c3,
                                        input int c4);
    return {8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  // Straight linear-scan reference: arg-min with tie rule, true second minimum, ratio test.
  function automatic void refModel(input logic [63:0] s, input int n, input bit tieLow,
                                   input int shift, input int invalid, input int uq,
                                   output int disp, output int minc, output int uniq);
    int best, idx, sec, c;
    best = 256; idx = 0; sec = 256;
    for (int k = 0; k < n; k++) begin
      c = int'(s[k*8 +: 8]);
      if (c < best || (c == best && !tieLow)) begin
        best = c;
        idx  = k;
      end
    end
    for (int k = 0; k < n; k++) begin
      c = int'(s[k*8 +: 8]);
      if (k != idx && c < sec) sec = c;
    end
    minc = best;
    uniq = (uq == 0 || 16 * (sec - best) >= best * uq) ? 1 : 0;
    disp = uniq ? ((idx << shift) & 255) : invalid;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkResult(input string tag, input int ev, input vec_t e);
    checkOutput({tag, "_vA"}, int'(vA), ev);
    checkOutput({tag, "_vB"}, int'(vB), ev);
    checkOutput({tag, "_vC"}, int'(vC), ev);
    if (ev != 0) begin
      checkOutput({tag, "_dA"}, int'(dA), e.dA);
      checkOutput({tag, "_mA"}, int'(mA), e.mAB);
      checkOutput({tag, "_uA"}, int'(uA), e.uAB);
      checkOutput({tag, "_dB"}, int'(dB), e.dB);
      checkOutput({tag, "_mB"}, int'(mB), e.mAB);
      checkOutput({tag, "_uB"}, int'(uB), e.uAB);
      checkOutput({tag, "_dC"}, int'(dC), e.dC);
      checkOutput({tag, "_mC"}, int'(mC), e.mC);
      checkOutput({tag, "_uC"}, int'(uC), e.uC);
    end
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_vA"}, int'(vA), 0);
    checkOutput({tag, "_dA"}, int'(dA), 0);
    checkOutput({tag, "_mA"}, int'(mA), 0);
    checkOutput({tag, "_uA"}, int'(uA), 0);
    checkOutput({tag, "_vC"}, int'(vC), 0);
    checkOutput({tag, "_dC"}, int'(dC), 0);
    checkOutput({tag, "_mC"}, int'(mC), 0);
    checkOutput({tag, "_uC"}, int'(uC), 0);
  endtask

  task automatic applyStimulus(input bit v, input logic [63:0] sab, input logic [39:0] sc,
                               input logic [3:0] uq, input bit en);
    iValid = v;
    sadsAB = sab;
    sadsC  = sc;
    iUniq  = uq;
    cEn    = en;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // After each enabled edge, the oldest pending pixel must emerge exactly when it is due.
  task automatic checkRandom();
    int   ev;
    vec_t e;
    ev = (q.size() > 0 && q[0].due == enEdge) ? 1 : 0;
    e  = tbl[0];
    if (ev != 0) e = q[0].e;
    checkResult("rand", ev, e);
    if (ev != 0) void'(q.pop_front());
  endtask

  // Main sequence: reset, directed table, c_en freeze, mid-stream reset, random stream.
  initial begin
    int   lat;
    bit   seen;
    bit   en, v;
    vec_t e;
    logic [63:0] rAB;
    logic [39:0] rC;
    logic [3:0]  rU;

    tbl[0]  = '{pack8(90,80,70,12,60,50,40,30),        pack5(255,255,255,255,255), 4'd0,
                96, 96, 12, 1, 16, 255, 1};
    tbl[1]  = '{pack8(20,5,30,5,99,99,99,99),          pack5(7,3,9,3,3),           4'd0,
                32, 96, 5, 1, 16, 3, 1};
    tbl[2]  = '{pack8(100,40,44,200,200,200,200,200),  pack5(50,60,70,80,44),      4'd2,
                7, 7, 40, 0, 16, 44, 1};
    tbl[3]  = '{pack8(100,40,44,200,200,200,200,200),  pack5(255,255,255,255,255), 4'd1,
                32, 32, 40, 1, 0, 255, 0};
    tbl[4]  = '{pack8(50,50,50,50,50,50,50,50),        pack5(9,1,5,5,5),           4'd1,
                7, 7, 50, 0, 4, 1, 1};
    tbl[5]  = '{pack8(50,50,50,50,50,50,50,50),        pack5(0,0,0,0,0),           4'd0,
                0, 224, 50, 1, 16, 0, 1};
    tbl[6]  = '{pack8(255,255,255,255,255,255,255,0),  pack5(12,200,200,200,13),   4'd15,
                224, 224, 0, 1, 0, 12, 0};
    tbl[7]  = '{pack8(10,20,30,40,50,60,70,80),        pack5(100,100,100,8,100),   4'd15,
                0, 0, 10, 1, 12, 8, 1};
    tbl[8]  = '{pack8(31,16,200,200,200,200,200,200),  pack5(20,20,20,20,255),     4'd15,
                32, 32, 16, 1, 0, 20, 0};
    tbl[9]  = '{pack8(30,16,200,200,200,200,200,200),  pack5(255,254,255,255,255), 4'd15,
                7, 7, 16, 0, 0, 254, 0};
    tbl[10] = '{pack8(64,32,100,100,100,100,100,100),  pack5(1,255,255,255,255),   4'd15,
                32, 32, 32, 1, 0, 1, 1};

    applyStimulus(1'b1, tbl[0].sab, tbl[0].sc, 4'd0, 1'b1);
    tick();
    tick();
    checkZero("reset");
    #3 aresetn = 1'b1;

    for (int j = 0; j < 14; j++) begin
      if (j < 11) applyStimulus(1'b1, tbl[j].sab, tbl[j].sc, tbl[j].uq, 1'b1);
      else        applyStimulus(1'b0, tbl[0].sab, tbl[0].sc, 4'd0, 1'b1);
      tick();
      if (j >= 3) checkResult($sformatf("vec%0d", j - 3), 1, tbl[j-3]);
      else        checkResult("vec_fill", 0, tbl[0]);
    end

    applyStimulus(1'b1, tbl[0].sab, tbl[0].sc, tbl[0].uq, 1'b1);
    tick();
    applyStimulus(1'b1, tbl[6].sab, tbl[6].sc, tbl[6].uq, 1'b0);
    for (int k = 0; k < 3; k++) begin tick(); checkOutput("cen_frozen", int'(vA), 0); end
    applyStimulus(1'b0, tbl[6].sab, tbl[6].sc, tbl[6].uq, 1'b1);
    for (int k = 0; k < 2; k++) begin tick(); checkOutput("cen_run", int'(vA), 0); end
    applyStimulus(1'b1, tbl[6].sab, tbl[6].sc, tbl[6].uq, 1'b0);
    for (int k = 0; k < 2; k++) begin tick(); checkOutput("cen_frozen2", int'(vA), 0); end
    applyStimulus(1'b0, tbl[6].sab, tbl[6].sc, tbl[6].uq, 1'b1);
    tick();
    checkResult("cen_out", 1, tbl[0]);
    applyStimulus(1'b1, tbl[6].sab, tbl[6].sc, tbl[6].uq, 1'b0);
    for (int k = 0; k < 3; k++) begin tick(); checkResult("cen_hold", 1, tbl[0]); end
    applyStimulus(1'b0, tbl[6].sab, tbl[6].sc, tbl[6].uq, 1'b1);
    tick();
    checkResult("cen_bubble", 0, tbl[0]);

    applyStimulus(1'b1, tbl[1].sab, tbl[1].sc, tbl[1].uq, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    checkResult("prerst", 1, tbl[1]);
    #3 aresetn = 1'b0;
    #1 checkZero("rst_async");
    tick();
    checkZero("rst_held");
    #3 aresetn = 1'b1;
    applyStimulus(1'b0, tbl[1].sab, tbl[1].sc, tbl[1].uq, 1'b1);
    for (int k = 0; k < 4; k++) begin tick(); checkOutput("rst_stale", int'(vA), 0); end
    applyStimulus(1'b1, tbl[0].sab, tbl[0].sc, tbl[0].uq, 1'b1);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      tick();
      applyStimulus(1'b0, tbl[0].sab, tbl[0].sc, tbl[0].uq, 1'b1);
      if (vA) begin seen = 1'b1; lat = k; end
    end
    checkOutput("rst_latency", lat, 4);
    if (seen) checkResult("rst_first", 1, tbl[0]);
    for (int k = 0; k < 4; k++) tick();

    for (int i = 0; i < 1000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 8; k++)
        rAB[k*8 +: 8] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      for (int k = 0; k < 5; k++)
        rC[k*8 +: 8] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      rU = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      applyStimulus(v, rAB, rC, rU, en);
      if (en && v) begin
        e.sab = rAB; e.sc = rC; e.uq = rU;
        refModel(rAB, 8, 1'b1, 5, 7, int'(rU), e.dA, e.mAB, e.uAB);
        refModel(rAB, 8, 1'b0, 5, 7, int'(rU), e.dB, e.mAB, e.uAB);
        refModel({24'b0, rC}, 5, 1'b0, 2, 0, int'(rU), e.dC, e.mC, e.uC);
        q.push_back('{e: e, due: enEdge + 4});
      end
      tick();
      if (en) begin
        enEdge++;
        checkRandom();
      end
    end
    applyStimulus(1'b0, tbl[0].sab, tbl[0].sc, 4'd0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      enEdge++;
      checkRandom();
    end
    checkOutput("rand_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
